// File: rtl/bus_rr_arbiter_pkg.sv
// Shared bus-owner types and constants for the system-bus arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: bus_owner_t (2-bit owner index), BUS_OWNER_MASTER_0..3,
//           BUS_HOLD_MAX default, ENABLE_/DISABLE_ active-low levels.
package bus_rr_arbiter_pkg;

  // Owner index; doubles as the master-side address/data mux select.
  typedef logic [1:0] bus_owner_t;

  localparam bus_owner_t BUS_OWNER_MASTER_0 = 2'h0;
  localparam bus_owner_t BUS_OWNER_MASTER_1 = 2'h1;
  localparam bus_owner_t BUS_OWNER_MASTER_2 = 2'h2;
  localparam bus_owner_t BUS_OWNER_MASTER_3 = 2'h3;

  localparam int BUS_NUM_M    = 4;
  localparam int BUS_HOLD_MAX = 16;

  // Request and grant lines are active-low.
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Grant level for master m given the current owner.
  function automatic logic grant_level(input bus_owner_t owner, input bus_owner_t m);
    return (owner == m) ? ENABLE_ : DISABLE_;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Round-robin next-owner search over the three masters after the current owner.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of owner and request vector.
// Ports: owner (current owner), req (active-high requests, one bit per master),
//        next_owner (first requester after owner, else owner), found (a requester exists).
module bus_rr_pick
  import bus_rr_arbiter_pkg::*;
(
  input  bus_owner_t owner,
  input  logic [3:0] req,
  output bus_owner_t next_owner,
  output logic       found
);

  bus_owner_t cand;

  // Walk from the farthest candidate back to owner+1 so the nearest one wins.
  // The owner itself is never a candidate; 2-bit addition wraps 3+1 to 0.
  always_comb begin
    next_owner = owner;
    found      = 1'b0;
    cand       = owner;
    for (int k = 3; k >= 1; k--) begin
      cand = owner + 2'(k);
      if (req[cand]) begin
        next_owner = cand;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_rr_arbiter.sv
// Round-robin arbiter granting the shared system bus to one of four masters.
// Latency: request to grant one cycle; a parked owner already holds its grant.
// Backpressure: owner holds while its req_ is low (bounded by HOLD_MAX when
//   BUS_ARB_HOLD_LIMIT_EN is defined); idle bus parks on the last owner.
// Ports: clk, reset (sync, active-high), m0..m3_req_ (active-low requests),
//        m0..m3_grnt_ (active-low one-hot grants), owner (mux select),
//        hold_err (one-cycle pulse on forced revocation, 0 without the macro).
// Optional feature macro: BUS_ARB_HOLD_LIMIT_EN.
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int NUM_M    = BUS_NUM_M,
  parameter int HOLD_MAX = BUS_HOLD_MAX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       m0_req_,
  input  logic       m1_req_,
  input  logic       m2_req_,
  input  logic       m3_req_,
  output logic       m0_grnt_,
  output logic       m1_grnt_,
  output logic       m2_grnt_,
  output logic       m3_grnt_,
  output bus_owner_t owner,
  output logic       hold_err
);

  bus_owner_t owner_q;
  bus_owner_t owner_d;
  bus_owner_t pick_owner;
  logic       pick_found;
  logic [3:0] req;
  logic       owner_req;
  logic       force_rot;

  // Active-high view of the requests.
  assign req = {m3_req_ == ENABLE_, m2_req_ == ENABLE_,
                m1_req_ == ENABLE_, m0_req_ == ENABLE_};

  assign owner_req = req[owner_q];

  bus_rr_pick u_pick (
    .owner      (owner_q),
    .req        (req),
    .next_owner (pick_owner),
    .found      (pick_found)
  );

`ifdef BUS_ARB_HOLD_LIMIT_EN
  localparam int CW = $clog2(HOLD_MAX) + 1;

  logic [CW-1:0] hold_cnt;
  logic          hold_err_q;

  // pick_found doubles as "another master is waiting": the search skips the owner.
  assign force_rot = owner_req && pick_found && (hold_cnt == CW'(HOLD_MAX - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_cnt   <= '0;
      hold_err_q <= 1'b0;
    end else begin
      // Count only contended holds; an owner change, a forced rotation or
      // an absent waiter all restart the count.
      if (owner_req && pick_found && !force_rot) begin
        hold_cnt <= hold_cnt + CW'(1);
      end else begin
        hold_cnt <= '0;
      end
      hold_err_q <= force_rot;
    end
  end

  assign hold_err = hold_err_q;
`else
  assign force_rot = 1'b0;
  assign hold_err  = 1'b0;
`endif

  // Hold while the owner requests (unless revoked); otherwise rotate to the
  // next requester, or park when nobody asks.
  always_comb begin
    owner_d = owner_q;
    if ((!owner_req || force_rot) && pick_found) begin
      owner_d = pick_owner;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q <= BUS_OWNER_MASTER_0;
    end else begin
      owner_q <= owner_d;
    end
  end

  assign owner    = owner_q;
  assign m0_grnt_ = grant_level(owner_q, BUS_OWNER_MASTER_0);
  assign m1_grnt_ = grant_level(owner_q, BUS_OWNER_MASTER_1);
  assign m2_grnt_ = grant_level(owner_q, BUS_OWNER_MASTER_2);
  assign m3_grnt_ = grant_level(owner_q, BUS_OWNER_MASTER_3);

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// Scoreboard bench for bus_rr_arbiter: directed test-plan sequences plus
// random traffic, checked against a rule-level reference model.
// Works with or without BUS_ARB_HOLD_LIMIT_EN defined.
module tb_bus_rr_arbiter;

  localparam int HM = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       m0_req_ = 1'b1, m1_req_ = 1'b1, m2_req_ = 1'b1, m3_req_ = 1'b1;
  logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_;
  logic [1:0] owner;
  logic       hold_err;

  bus_rr_arbiter #(.NUM_M(4), .HOLD_MAX(HM)) dut (
    .clk(clk), .reset(reset),
    .m0_req_(m0_req_), .m1_req_(m1_req_), .m2_req_(m2_req_), .m3_req_(m3_req_),
    .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
    .owner(owner), .hold_err(hold_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] own;
    logic       herr;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state (plain integers).
  int   m_owner  = 0;
  int   m_cnt    = 0;
  int   m_tenure = 0;
  logic m_herr   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of the arbitration rules applied to an active-high request set.
  task automatic model_step(input logic rst, input logic [3:0] req);
    int  prev;
    int  first;
    bit  waiter;
    prev   = m_owner;
    first  = -1;
    waiter = 0;
    for (int k = 1; k <= 3; k++) begin
      if (req[(m_owner + k) % 4] && first < 0) first = (m_owner + k) % 4;
    end
    waiter = (first >= 0);
    m_herr = 1'b0;
    if (rst) begin
      m_owner = 0;
      m_cnt   = 0;
    end else if (req[m_owner]) begin
`ifdef BUS_ARB_HOLD_LIMIT_EN
      if (!waiter) begin
        m_cnt = 0;
      end else if (m_cnt == HM - 1) begin
        m_owner = first;
        m_cnt   = 0;
        m_herr  = 1'b1;
      end else begin
        m_cnt = m_cnt + 1;
      end
`endif
    end else begin
      if (waiter) m_owner = first;
      m_cnt = 0;
    end
    m_tenure = (m_owner != prev || rst) ? 1 : m_tenure + 1;
  endtask

  task automatic drive(input logic rst, input logic [3:0] req);
    exp_t e;
    @(negedge clk);
    reset   = rst;
    m0_req_ = ~req[0];
    m1_req_ = ~req[1];
    m2_req_ = ~req[2];
    m3_req_ = ~req[3];
    model_step(rst, req);
    e.own  = 2'(m_owner);
    e.herr = m_herr;
    q.push_back(e);
  endtask

  // Monitor: the DUT presents owner/grants every cycle; compare after each edge.
  initial begin
    exp_t       e;
    logic [3:0] g;
    logic [3:0] eg;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e  = q.pop_front();
        g  = {m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_};
        eg = ~(4'b0001 << e.own);
        chk("owner", int'(owner), int'(e.own));
        chk("grants", int'(g), int'(eg));
        chk("one_grant_low", $countones(~g), 1);
        chk("hold_err", int'(hold_err), int'(e.herr));
      end
    end
  end

  initial begin
    logic [3:0] r;
    // 1: reset two cycles, then idle parking on master 0.
    repeat (2) drive(1'b1, 4'b0000);
    repeat (10) drive(1'b0, 4'b0000);
    // 2: lone m2 request, then release -> stays parked on 2.
    repeat (4) drive(1'b0, 4'b0100);
    repeat (4) drive(1'b0, 4'b0000);
    // 3: everyone requests; owner drops req_ for one cycle after 3 owned cycles.
    drive(1'b1, 4'b0000);
    for (int i = 0; i < 24; i++) begin
      r = 4'b1111;
      if (m_tenure >= 3) r[m_owner] = 1'b0;
      drive(1'b0, r);
    end
    // 4: owner 3 releases while m0 and m1 request -> wraps to 0.
    repeat (2) drive(1'b0, 4'b1000);
    repeat (2) drive(1'b0, 4'b1011);
    repeat (2) drive(1'b0, 4'b0011);
    // 5: sync reset mid-transfer by m2, then m2 regains the bus.
    repeat (3) drive(1'b0, 4'b0100);
    drive(1'b1, 4'b0100);
    repeat (3) drive(1'b0, 4'b0100);
    // 6: m1 holds, m2 waits -> forced rotation only with the hold limit.
    repeat (2) drive(1'b0, 4'b0010);
    repeat (10) drive(1'b0, 4'b0110);
    // Random traffic with occasional resets; bias toward sticky requests.
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      drive(($urandom_range(0, 59) == 0), r);
    end
    drive(1'b0, 4'b0000);
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
